// File: rtl/lane_pipe_arbiter.sv
// Four-lane round-robin arbiter feeding one shared two-stage register pipeline.
// A grant in cycle N is delivered in cycle N+2; hold freezes the pipeline and the pointer.
module lane_pipe_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] in_data,
  input  logic           hold,
  output logic [3:0]     gnt,
  output logic [3:0]     out_valid,
  output logic [W-1:0]   out_data,
  output logic           busy
);

  logic [1:0]   ptr_q, ptr_d;
  logic         vld_p1_q, vld_p1_d;
  logic [1:0]   tag_p1_q, tag_p1_d;
  logic [W-1:0] data_p1_q, data_p1_d;
  logic         vld_p2_q, vld_p2_d;
  logic [1:0]   tag_p2_q, tag_p2_d;
  logic [W-1:0] data_p2_q, data_p2_d;

  logic         win_vld;
  logic [1:0]   win_tag;
  logic [1:0]   idx;
  logic [W-1:0] win_data;
  logic         gnt_any;

  // Arbitration: scan from the farthest offset down so the lane closest to ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_tag = 2'd0;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + i[1:0];
      if (req[idx]) begin
        win_vld = 1'b1;
        win_tag = idx;
      end
    end
    win_data = in_data[win_tag*W +: W];
    gnt_any  = rst_n && !hold && win_vld;
    gnt      = gnt_any ? (4'b0001 << win_tag) : 4'b0000;
  end

  always_comb begin
    ptr_d     = ptr_q;
    vld_p1_d  = vld_p1_q;
    tag_p1_d  = tag_p1_q;
    data_p1_d = data_p1_q;
    vld_p2_d  = vld_p2_q;
    tag_p2_d  = tag_p2_q;
    data_p2_d = data_p2_q;
    if (!hold) begin
      // Stage 1: capture the winner (or a bubble)
      vld_p1_d  = gnt_any;
      tag_p1_d  = win_tag;
      data_p1_d = win_data;
      // Stage 2: advance stage 1
      vld_p2_d  = vld_p1_q;
      tag_p2_d  = tag_p1_q;
      data_p2_d = data_p1_q;
      if (gnt_any) ptr_d = win_tag + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= 2'd0;
      vld_p1_q  <= 1'b0;
      tag_p1_q  <= 2'd0;
      data_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      tag_p2_q  <= 2'd0;
      data_p2_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      vld_p1_q  <= vld_p1_d;
      tag_p1_q  <= tag_p1_d;
      data_p1_q <= data_p1_d;
      vld_p2_q  <= vld_p2_d;
      tag_p2_q  <= tag_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

  // Delivery is suppressed during hold; the entry stays in stage 2 for the next cycle.
  always_comb begin
    out_valid = (vld_p2_q && !hold) ? (4'b0001 << tag_p2_q) : 4'b0000;
    out_data  = (out_valid != 4'b0000) ? data_p2_q : '0;
    busy      = vld_p1_q || vld_p2_q;
  end

endmodule

// File: doc/lane_pipe_arbiter.md
LANE_PIPE_ARBITER -- requirements
Module: lane_pipe_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8: data width per lane.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have port req, input, 4: per-lane request; a requester holds req[i] high until it is granted.
REQ-005 The block SHALL have port in_data, input, 4*W: lane i data at bits [i*W +: W].
REQ-006 The block SHALL have port hold, input, 1: stall; while high, no grant is issued and the pipeline freezes.
REQ-007 The block SHALL have port gnt, output, 4: combinational, one-hot or zero; lane i data is captured at the edge ending a cycle with gnt[i]=1.
REQ-008 The block SHALL have port out_valid, output, 4: one-hot or zero; marks the delivery lane.
REQ-009 The block SHALL have port out_data, output, W: delivered data; 0 when out_valid=0.
REQ-010 The block SHALL have port busy, output, 1: high when any pipeline stage holds a valid entry.

Function
REQ-011 The block SHALL share one 2-stage register pipeline (s1, s2) among 4 lanes; each stage SHALL hold valid, a 2-bit lane tag and W data bits.
REQ-012 Round-robin pointer ptr (2 bits) SHALL select the winner as the first lane with req set, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-013 gnt SHALL be the one-hot winner when hold=0 and rst_n=1, and SHALL be 0 otherwise or when req=0.
REQ-014 On an edge with a grant to lane k, ptr SHALL become (k+1) mod 4; with no grant, ptr SHALL be unchanged.
REQ-015 On an edge with hold=0: s1 SHALL take {gnt!=0, winner tag, winner data}, and s2 SHALL take s1.
REQ-016 On an edge with hold=1: s1, s2 and ptr SHALL be unchanged.
REQ-017 out_valid SHALL equal the one-hot decode of the s2 tag when the s2 entry is valid and hold=0; otherwise out_valid=0.
REQ-018 out_data SHALL equal the s2 data when out_valid!=0.
REQ-019 Latency: data granted in cycle N SHALL appear on out_valid/out_data in cycle N+2 when no hold occurs.
REQ-020 Each hold cycle SHALL add exactly one cycle of delay.
REQ-021 Each granted entry SHALL be delivered exactly once.
REQ-022 Throughput SHALL be one grant per non-hold cycle.
REQ-023 Delivery order SHALL match grant order.
REQ-024 busy SHALL equal s1.valid OR s2.valid, and SHALL be unaffected by hold.
REQ-025 A request that arrives while hold=1 SHALL be arbitrated normally in the first cycle with hold=0.

Reset
REQ-026 On a rising edge with rst_n=0: ptr, s1 and s2 (valid, tag, data) SHALL clear to 0, and any in-flight entries SHALL be discarded without delivery.
REQ-027 While rst_n=0, gnt SHALL be 0.
REQ-028 After the reset edge, out_valid, out_data and busy SHALL be 0.
REQ-029 Reset SHALL take priority over hold.

Verification
REQ-030 A bench SHALL cover: reset, then req=0100 with lane-2 data 0xA5 in cycle 0 -> gnt=0100 in cycle 0; out_valid=0100 and out_data=0xA5 in cycle 2; busy high in cycles 1-2.
REQ-031 A bench SHALL cover: reset, then req=1111 held continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001; out_valid repeats the same sequence offset by 2 cycles.
REQ-032 A bench SHALL cover: after lane 1 is granted (ptr=2), req=0011 -> gnt=0001; then with req=0010, gnt=0010 in the next cycle.
REQ-033 A bench SHALL cover: lane-0 data 0x3C granted in cycle 0, hold=1 in cycles 1-2 -> gnt=0 and out_valid=0 in cycles 1-3; out_valid=0001 with out_data=0x3C in cycle 4 only.
REQ-034 A bench SHALL cover: grants in cycles 0 and 1, then rst_n=0 at the edge ending cycle 1 -> no out_valid in any later cycle; busy=0 and ptr=0 (next req=1111 -> gnt=0001).
REQ-035 A bench SHALL cover: req=0 for 5 cycles after a lane-3 grant -> gnt=0 throughout; next req=1001 -> gnt=0001 (ptr remained 0).
